// File: rtl/wildcard_seq_detector_if.sv
// Config, input-beat, hit-handshake and status bundle for wildcard_seq_detector.
// slave = detector side, master = driver/consumer side.
interface wildcard_seq_detector_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              i_cfg_we;
    logic [3:0]        i_cfg_addr;
    logic [DATA_W-1:0] i_cfg_pattern;
    logic [DATA_W-1:0] i_cfg_mask;
    logic              o_cfg_err;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [DATA_W-1:0] i_in_data;
    logic              o_hit_valid;
    logic              i_hit_ready;
    logic [3:0]        o_state;
    logic [CNT_W-1:0]  o_hit_count;

    modport slave (
        input  i_cfg_we, i_cfg_addr, i_cfg_pattern, i_cfg_mask,
        input  i_in_valid, i_in_data, i_hit_ready,
        output o_cfg_err, o_in_ready, o_hit_valid, o_state, o_hit_count
    );

    modport master (
        output i_cfg_we, i_cfg_addr, i_cfg_pattern, i_cfg_mask,
        output i_in_valid, i_in_data, i_hit_ready,
        input  o_cfg_err, o_in_ready, o_hit_valid, o_state, o_hit_count
    );
endinterface

// File: rtl/wildcard_seq_detector.sv
// Detects entry0..entry[DEPTH-1] on consecutive accepted beats using masked compare.
// Define WILDCARD_SEQ_OVERLAP_EN to re-check the final beat of a hit against entry 0.
module wildcard_seq_detector #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input logic                  i_clk,
    input logic                  i_rst,
    wildcard_seq_detector_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [DATA_W-1:0] pattern_q [DEPTH];
    logic [DATA_W-1:0] mask_q    [DEPTH];
    logic [IDX_W-1:0]  state_q;
    logic              hit_valid_q;
    logic              cfg_err_q;
    logic [CNT_W-1:0]  hit_count_q;

    logic accept;
    logic addr_ok;
    logic match_cur;
    logic match_first;
    logic [IDX_W-1:0] after_hit;

    always_comb begin
        accept      = bus.i_in_valid && !hit_valid_q;
        addr_ok     = ({1'b0, bus.i_cfg_addr} < 5'(DEPTH));
        match_cur   = (((bus.i_in_data ^ pattern_q[state_q]) & ~mask_q[state_q]) == '0);
        match_first = (((bus.i_in_data ^ pattern_q[0]) & ~mask_q[0]) == '0);
`ifdef WILDCARD_SEQ_OVERLAP_EN
        after_hit   = match_first ? IDX_W'(1) : '0;
`else
        after_hit   = '0;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                pattern_q[k] <= '0;
                mask_q[k]    <= '0;
            end
            state_q     <= '0;
            hit_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            hit_count_q <= '0;
        end else begin
            cfg_err_q <= bus.i_cfg_we && !addr_ok;

            if (hit_valid_q && bus.i_hit_ready)
                hit_valid_q <= 1'b0;

            // A valid config write overrides any beat accepted on the same edge.
            if (bus.i_cfg_we && addr_ok) begin
                pattern_q[bus.i_cfg_addr[IDX_W-1:0]] <= bus.i_cfg_pattern;
                mask_q[bus.i_cfg_addr[IDX_W-1:0]]    <= bus.i_cfg_mask;
                state_q                              <= '0;
            end else if (accept) begin
                if (match_cur) begin
                    if (state_q == LAST_IDX) begin
                        hit_valid_q <= 1'b1;
                        state_q     <= after_hit;
                        if (hit_count_q != '1)
                            hit_count_q <= hit_count_q + 1'b1;
                    end else begin
                        state_q <= state_q + 1'b1;
                    end
                end else begin
                    state_q <= match_first ? IDX_W'(1) : '0;
                end
            end
        end
    end

    assign bus.o_in_ready  = !hit_valid_q;
    assign bus.o_hit_valid = hit_valid_q;
    assign bus.o_cfg_err   = cfg_err_q;
    assign bus.o_state     = 4'(state_q);
    assign bus.o_hit_count = hit_count_q;
endmodule

// File: tb/tb_wildcard_seq_detector.sv
// Directed bench for wildcard_seq_detector: main instance (CNT_W=8) plus a CNT_W=2 instance.
module tb_wildcard_seq_detector;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wildcard_seq_detector_if #(.DATA_W(8), .CNT_W(8)) bus ();
    wildcard_seq_detector_if #(.DATA_W(8), .CNT_W(2)) bus2 ();

    wildcard_seq_detector #(.DATA_W(8), .DEPTH(4), .CNT_W(8)) u_dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );

    wildcard_seq_detector #(.DATA_W(8), .DEPTH(4), .CNT_W(2)) u_sat (
        .i_clk(clk), .i_rst(rst), .bus(bus2)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] p, input logic [7:0] m);
        bus.i_cfg_we = 1'b1; bus.i_cfg_addr = a; bus.i_cfg_pattern = p; bus.i_cfg_mask = m;
        tick();
        bus.i_cfg_we = 1'b0;
    endtask

    task automatic cfg_write2(input logic [3:0] a, input logic [7:0] p, input logic [7:0] m);
        bus2.i_cfg_we = 1'b1; bus2.i_cfg_addr = a; bus2.i_cfg_pattern = p; bus2.i_cfg_mask = m;
        tick();
        bus2.i_cfg_we = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        bus.i_in_valid = 1'b1; bus.i_in_data = d;
        tick();
        bus.i_in_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] d);
        bus2.i_in_valid = 1'b1; bus2.i_in_data = d;
        tick();
        bus2.i_in_valid = 1'b0;
    endtask

    task automatic ack();
        bus.i_hit_ready = 1'b1;
        tick();
        bus.i_hit_ready = 1'b0;
    endtask

    task automatic setup_table_a();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg_write(4'd0, 8'hA5, 8'h00);
        cfg_write(4'd1, 8'h3C, 8'h0F);
        cfg_write(4'd2, 8'h00, 8'hFF);
        cfg_write(4'd3, 8'h5A, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.o_state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.o_state); end
        checks++; if (bus.o_hit_valid !== 1'b0) begin errors++; $display("FAIL reset_hit_valid: got %0b expected 0", bus.o_hit_valid); end
        checks++; if (bus.o_hit_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.o_hit_count); end
        checks++; if (bus.o_cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %0b expected 0", bus.o_cfg_err); end
        checks++; if (bus.o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", bus.o_in_ready); end
        checks++; if (bus2.o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_sat_in_ready: got %0b expected 1", bus2.o_in_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] beats [3];
        logic [3:0] exp_st [3];
        beats  = '{8'hA5, 8'h37, 8'h77};
        exp_st = '{4'd1, 4'd2, 4'd3};
        setup_table_a();
        for (int i = 0; i < 3; i++) begin
            send(beats[i]);
            checks++; if (bus.o_state !== exp_st[i]) begin errors++; $display("FAIL basic_state%0d: got %0d expected %0d", i, bus.o_state, exp_st[i]); end
        end
        send(8'h5A);
        checks++; if (bus.o_hit_valid !== 1'b1) begin errors++; $display("FAIL basic_hit_valid: got %0b expected 1", bus.o_hit_valid); end
        checks++; if (bus.o_hit_count !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", bus.o_hit_count); end
        checks++; if (bus.o_state !== 4'd0) begin errors++; $display("FAIL basic_state_after_hit: got %0d expected 0", bus.o_state); end
        checks++; if (bus.o_in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_pending: got %0b expected 0", bus.o_in_ready); end
        ack();
        checks++; if (bus.o_hit_valid !== 1'b0) begin errors++; $display("FAIL basic_hit_cleared: got %0b expected 0", bus.o_hit_valid); end
    endtask

    task automatic test_restart();
        logic [7:0] beats [4];
        logic [3:0] exp_st [4];
        beats  = '{8'hA5, 8'hA5, 8'h3C, 8'h11};
        exp_st = '{4'd1, 4'd1, 4'd2, 4'd3};
        setup_table_a();
        for (int i = 0; i < 4; i++) begin
            send(beats[i]);
            checks++; if (bus.o_state !== exp_st[i]) begin errors++; $display("FAIL restart_state%0d: got %0d expected %0d", i, bus.o_state, exp_st[i]); end
        end
        send(8'h5A);
        checks++; if (bus.o_hit_valid !== 1'b1) begin errors++; $display("FAIL restart_hit_valid: got %0b expected 1", bus.o_hit_valid); end
        checks++; if (bus.o_hit_count !== 8'd1) begin errors++; $display("FAIL restart_count: got %0d expected 1", bus.o_hit_count); end
        ack();
    endtask

    task automatic test_stall();
        setup_table_a();
        send(8'hA5); send(8'h37); send(8'h77); send(8'h5A);
        bus.i_in_valid = 1'b1; bus.i_in_data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.o_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d: got %0b expected 0", i, bus.o_in_ready); end
            checks++; if (bus.o_state !== 4'd0) begin errors++; $display("FAIL stall_state%0d: got %0d expected 0", i, bus.o_state); end
            checks++; if (bus.o_hit_valid !== 1'b1) begin errors++; $display("FAIL stall_hit_valid%0d: got %0b expected 1", i, bus.o_hit_valid); end
        end
        bus.i_hit_ready = 1'b1;
        tick();
        bus.i_hit_ready = 1'b0;
        bus.i_in_valid = 1'b0;
        checks++; if (bus.o_hit_valid !== 1'b0) begin errors++; $display("FAIL stall_release_hit: got %0b expected 0", bus.o_hit_valid); end
        checks++; if (bus.o_in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0b expected 1", bus.o_in_ready); end
        checks++; if (bus.o_state !== 4'd0) begin errors++; $display("FAIL stall_release_state: got %0d expected 0", bus.o_state); end
        checks++; if (bus.o_hit_count !== 8'd1) begin errors++; $display("FAIL stall_count: got %0d expected 1", bus.o_hit_count); end
    endtask

    task automatic test_cfg_err();
        logic [3:0] bad [2];
        bad = '{4'd4, 4'd15};
        setup_table_a();
        send(8'hA5); send(8'h37);
        for (int i = 0; i < 2; i++) begin
            cfg_write(bad[i], 8'h00, 8'h00);
            checks++; if (bus.o_cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse%0d: got %0b expected 1", i, bus.o_cfg_err); end
            checks++; if (bus.o_state !== 4'd2) begin errors++; $display("FAIL cfg_err_state%0d: got %0d expected 2", i, bus.o_state); end
            tick();
            checks++; if (bus.o_cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear%0d: got %0b expected 0", i, bus.o_cfg_err); end
        end
        send(8'h77); send(8'h5A);
        checks++; if (bus.o_hit_valid !== 1'b1) begin errors++; $display("FAIL cfg_err_table_kept: got %0b expected 1", bus.o_hit_valid); end
        ack();
        send(8'hA5); send(8'h37);
        bus.i_in_valid = 1'b1; bus.i_in_data = 8'h77;
        cfg_write(4'd2, 8'h00, 8'hFF);
        bus.i_in_valid = 1'b0;
        checks++; if (bus.o_state !== 4'd0) begin errors++; $display("FAIL cfg_write_state: got %0d expected 0", bus.o_state); end
        checks++; if (bus.o_cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_write_err: got %0b expected 0", bus.o_cfg_err); end
        checks++; if (bus.o_hit_count !== 8'd1) begin errors++; $display("FAIL cfg_write_count: got %0d expected 1", bus.o_hit_count); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        bit got;
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) cfg_write2(4'(k), 8'h00, 8'hFF);
        for (int h = 0; h < 5; h++) begin
            got = 1'b0;
            for (int b = 0; b < 8 && !got; b++) begin
                send2(8'h3C);
                got = bus2.o_hit_valid;
            end
            checks++; if (!got) begin errors++; $display("FAIL sat_hit%0d: got no hit expected hit within 8 beats", h); end
            checks++; if (bus2.o_hit_count !== exp_cnt[h]) begin errors++; $display("FAIL sat_count%0d: got %0d expected %0d", h, bus2.o_hit_count, exp_cnt[h]); end
            bus2.i_hit_ready = 1'b1;
            tick();
            bus2.i_hit_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        setup_table_a();
        for (int k = 0; k < 4; k++) cfg_write2(4'(k), 8'h00, 8'hFF);
        send(8'hA5); send(8'h37);
        for (int b = 0; b < 4; b++) send2(8'h81);
        checks++; if (bus.o_state !== 4'd2) begin errors++; $display("FAIL mid_pre_state: got %0d expected 2", bus.o_state); end
        checks++; if (bus2.o_hit_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_hit: got %0b expected 1", bus2.o_hit_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.o_state !== 4'd0) begin errors++; $display("FAIL mid_state: got %0d expected 0", bus.o_state); end
        checks++; if (bus.o_in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %0b expected 1", bus.o_in_ready); end
        checks++; if (bus.o_cfg_err !== 1'b0) begin errors++; $display("FAIL mid_cfg_err: got %0b expected 0", bus.o_cfg_err); end
        checks++; if (bus2.o_hit_valid !== 1'b0) begin errors++; $display("FAIL mid_sat_hit: got %0b expected 0", bus2.o_hit_valid); end
        checks++; if (bus2.o_hit_count !== 2'd0) begin errors++; $display("FAIL mid_sat_count: got %0d expected 0", bus2.o_hit_count); end
        checks++; if (bus2.o_in_ready !== 1'b1) begin errors++; $display("FAIL mid_sat_ready: got %0b expected 1", bus2.o_in_ready); end
        // table cleared to pattern 0 / mask 0: 00 matches entry0, 01 matches nothing
        send(8'h00);
        checks++; if (bus.o_state !== 4'd1) begin errors++; $display("FAIL mid_table0: got %0d expected 1", bus.o_state); end
        send(8'h01);
        checks++; if (bus.o_state !== 4'd0) begin errors++; $display("FAIL mid_table1: got %0d expected 0", bus.o_state); end
    endtask

    task automatic test_overlap();
        logic [7:0] hits;
        logic [7:0] exp_hits;
        logic [7:0] exp_count;
        logic [3:0] exp_state;
`ifdef WILDCARD_SEQ_OVERLAP_EN
        exp_hits = 8'b1001_0000; exp_count = 8'd2; exp_state = 4'd1;
`else
        exp_hits = 8'b0001_0000; exp_count = 8'd1; exp_state = 4'd3;
`endif
        hits = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) cfg_write(4'(k), 8'hA5, 8'h00);
        for (int b = 1; b <= 7; b++) begin
            checks++; if (bus.o_in_ready !== 1'b1) begin errors++; $display("FAIL overlap_ready%0d: got %0b expected 1", b, bus.o_in_ready); end
            send(8'hA5);
            if (bus.o_hit_valid === 1'b1) begin
                hits[b] = 1'b1;
                ack();
            end
        end
        checks++; if (hits !== exp_hits) begin errors++; $display("FAIL overlap_hit_beats: got %b expected %b", hits, exp_hits); end
        checks++; if (bus.o_hit_count !== exp_count) begin errors++; $display("FAIL overlap_count: got %0d expected %0d", bus.o_hit_count, exp_count); end
        checks++; if (bus.o_state !== exp_state) begin errors++; $display("FAIL overlap_state: got %0d expected %0d", bus.o_state, exp_state); end
    endtask

    initial begin
        bus.i_cfg_we = 1'b0; bus.i_cfg_addr = '0; bus.i_cfg_pattern = '0; bus.i_cfg_mask = '0;
        bus.i_in_valid = 1'b0; bus.i_in_data = '0; bus.i_hit_ready = 1'b0;
        bus2.i_cfg_we = 1'b0; bus2.i_cfg_addr = '0; bus2.i_cfg_pattern = '0; bus2.i_cfg_mask = '0;
        bus2.i_in_valid = 1'b0; bus2.i_in_data = '0; bus2.i_hit_ready = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_restart();
        test_stall();
        test_cfg_err();
        test_saturation();
        test_reset_mid();
        test_overlap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wildcard_seq_detector.md
Name: wildcard_seq_detector

Overview:
- Streaming byte scanner that compares each accepted input beat against a programmable table of DEPTH pattern/mask entries, using wildcard-equality semantics.
- Detects the ordered sequence entry0, entry1, ..., entry[DEPTH-1] on consecutive accepted beats.
- Emits a hit event on a valid/ready output and keeps a saturating hit counter.
- Sits upstream of the wildcard-compare/status logic: it produces the hit stream and counts that the status logic consumes.
- Config writes use a bounded index; out-of-range writes are dropped and flagged.

Parameters:
- DATA_W, 8, beat and pattern width.
- DEPTH, 4, number of sequence entries (2..16).
- CNT_W, 8, hit counter width.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_cfg_we  input  1  table write strobe.
- i_cfg_addr  input  4  table index.
- i_cfg_pattern  input  DATA_W  pattern value.
- i_cfg_mask  input  DATA_W  don't-care mask, 1 = bit ignored.
- o_cfg_err  output  1  one-cycle pulse: dropped out-of-range write.
- i_in_valid  input  1  input beat valid.
- o_in_ready  output  1  input beat ready.
- i_in_data  input  DATA_W  input beat.
- o_hit_valid  output  1  hit event pending.
- i_hit_ready  input  1  consumer accepts hit.
- o_state  output  4  index of next expected entry.
- o_hit_count  output  CNT_W  saturating hit count.

Behaviour:
- Reset: synchronous on i_rst=1 at a clock edge.
  - All patterns are reset to 0 and all masks to 0.
  - Outputs at reset: o_state=0, o_hit_valid=0, o_hit_count=0, o_cfg_err=0.
  - o_in_ready=1 after reset.
  - Reset mid-sequence or with a hit pending discards both.
- Match function: beat d matches entry k iff ((d ^ pattern[k]) & ~mask[k]) == 0. A mask of all-ones matches any beat.
- Accept: a beat is accepted when i_in_valid && o_in_ready.
  - o_in_ready = ~o_hit_valid. This is a registered term: no beat is accepted while a hit is pending.
- State update on an accepted beat, with s = o_state:
  - If the beat matches entry s and s < DEPTH-1: s <= s+1.
  - If the beat matches entry s and s == DEPTH-1: hit. Set o_hit_valid <= 1 on the next cycle (latency 1 from the accepting edge). Then s <= 0, or s <= 1 under the overlap feature.
  - If the beat does not match entry s: restart. s <= 1 if the beat matches entry 0, else s <= 0.
- No accepted beat: state holds.
- Hit handshake:
  - o_hit_valid is cleared on the cycle where o_hit_valid && i_hit_ready.
  - o_hit_count increments by 1 when a hit is generated and saturates at 2^CNT_W-1.
  - A hit cannot be generated while one is pending, because input is stalled.
- Config write (i_cfg_we=1):
  - i_cfg_addr < DEPTH: writes pattern/mask and forces s <= 0 on the same edge. Config wins over a simultaneous accepted beat; the beat is consumed but ignored. o_hit_valid and the count are unaffected.
  - i_cfg_addr >= DEPTH: table and state are unchanged, and o_cfg_err=1 for exactly the next cycle.
- Table reads are always in range. o_state never exceeds DEPTH-1.

Optional Feature:
- Macro: WILDCARD_SEQ_OVERLAP_EN.
- Defined: after a hit, the final beat is re-checked against entry 0. s <= 1 if it matches, else 0, so overlapping sequences are detected.
- Undefined: s <= 0 after every hit, so sequences are non-overlapping.

Test Plan:
- Table setup for the scenarios below (DEPTH=4): entry0 A5/mask 00, entry1 3C/mask 0F, entry2 00/mask FF, entry3 5A/mask 00.
  - Stream A5,37,77,5A with no gaps.
  - Required: o_state 1,2,3 after the first three beats.
  - Required: o_hit_valid=1 one cycle after the 5A beat, o_hit_count=1, o_state=0.
- Same table, stream A5,A5,3C,11,5A.
  - Required: the second A5 mismatches entry1, restarts and gives s=1.
  - Required: a hit is produced after 5A, count=1.
- Hold i_hit_ready=0 for 3 cycles after a hit with i_in_valid=1.
  - Required: o_in_ready=0 and o_state stable.
  - Required: when i_hit_ready=1, o_hit_valid drops next cycle and o_in_ready returns to 1.
- Write to i_cfg_addr=4, then 15.
  - Required: the table is unchanged and o_cfg_err pulses once per write, one cycle each.
  - Required: a valid write at addr 2 mid-sequence (s=2) forces s=0.
- CNT_W=2, generate 5 hits.
  - Required: o_hit_count reads 1,2,3,3,3.
  - Required: assert i_rst for one cycle mid-sequence with a hit pending, then check that all outputs return to reset values.
- Table A5,A5,A5,A5 (masks 00), stream seven A5 beats.
  - WILDCARD_SEQ_OVERLAP_EN defined: hits after beats 4 and 7. Acknowledge each hit immediately; beats are stalled while a hit is pending.
  - WILDCARD_SEQ_OVERLAP_EN undefined: only 1 hit, after beat 4.
